// File: rtl/ram_dp_sweep.sv
// rtl/ram_dp_sweep.sv - simple dual-port RAM with 2-cycle read and init sweep (option: RAM_BYPASS_EN)
module ram_dp_sweep #(
  parameter int                 DATA_W   = 3,
  parameter int                 ADDR_W   = 5,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] datain,
  input  logic              wren,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   wa_q;
  logic [DATA_W-1:0]   wd_q;
  logic                we_q;
  logic                re_q;

  logic [DATA_W-1:0]   dout_q;
  logic                rv_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;
  logic [DATA_W-1:0]   rd_next;

  assign busy = (state_q == ST_SWEEP);

  // Sweep sequencer: state and address counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep next state: walk every word once, then wait for a clear request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_SWEEP) begin
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end else begin
      // clear only matters from IDLE, so a request during a sweep never restarts it
      if (clear) begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    end
  end

  // Capture stage: address/data follow enable; strobes are blocked while sweeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      wa_q <= '0;
      wd_q <= '0;
      we_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      if (enable) begin
        rd_q <= rdaddress;
        wa_q <= wraddress;
        wd_q <= datain;
      end
      we_q <= wren & enable & ~busy;
      re_q <= enable & ~busy;
    end
  end

  // Single write port shared between the sweep and user writes; the sweep owns it while busy
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa_q;
    mem_wd = wd_q;
    if (busy) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = INIT_VAL;
    end else if (we_q) begin
      mem_we = 1'b1;
    end
  end

  // Storage array: no reset, contents change only through the write port
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read data source: old contents by default, write-through on same-address collision when bypass is built
  always_comb begin
`ifdef RAM_BYPASS_EN
    if (we_q && re_q && (wa_q == rd_q)) begin
      rd_next = wd_q;
    end else begin
      rd_next = mem[rd_q];
    end
`else
    rd_next = mem[rd_q];
`endif
  end

  // Memory stage output register: holds data when no read is issued, cleared while sweeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      rv_q   <= 1'b0;
    end else if (busy) begin
      dout_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      rv_q <= re_q;
      if (re_q) begin
        dout_q <= rd_next;
      end
    end
  end

  // The first busy cycle after a clear still sees a read launched at the clear edge, so gate here too
  assign dataout  = busy ? '0 : dout_q;
  assign rd_valid = rv_q & ~busy;

endmodule

// File: tb/tb_ram_dp_sweep.sv
// tb/tb_ram_dp_sweep.sv - directed table-driven bench for ram_dp_sweep
module tb_ram_dp_sweep;

  localparam int DW = 3;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam logic [DW-1:0] INIT = 3'b101;
`ifdef RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          enable;
  logic          clear;
  logic [AW-1:0] rdaddress;
  logic [AW-1:0] wraddress;
  logic [DW-1:0] datain;
  logic          wren;
  logic [DW-1:0] dataout;
  logic          rd_valid;
  logic          busy;

  ram_dp_sweep #(.DATA_W(DW), .ADDR_W(AW), .INIT_VAL(INIT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .rdaddress(rdaddress), .wraddress(wraddress), .datain(datain), .wren(wren),
    .dataout(dataout), .rd_valid(rd_valid), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          en;
    logic          we;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] d;
    logic          ev;
    logic          cd;
    logic [DW-1:0] ed;
    logic [DW-1:0] edb;
  } vec_t;

  vec_t          tbl [10];
  logic [DW-1:0] model [DEPTH];
  int            passed;
  int            total;
  int            n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts edges until busy drops; outputs must stay zero while busy.
  task automatic sweep_count(input string name, input int clear_at, output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      clear = (cnt == clear_at);
      wraddress = cnt[AW-1:0];
      tick();
      cnt++;
      if (busy) begin
        chk({name, " dataout"}, 64'(dataout), 64'(0));
        chk({name, " rd_valid"}, 64'(rd_valid), 64'(0));
      end
    end
    clear = 1'b0;
    chk({name, " length"}, 64'(cnt), 64'(DEPTH));
  endtask

  task automatic read_all(input string name);
    wren = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      enable = (i < DEPTH);
      rdaddress = i[AW-1:0];
      tick();
      if (i >= 1 && i <= DEPTH) begin
        chk($sformatf("%s valid %0d", name, i - 1), 64'(rd_valid), 64'(1));
        chk($sformatf("%s data %0d", name, i - 1), 64'(dataout), 64'(model[i-1]));
      end else if (i == DEPTH + 1) begin
        chk($sformatf("%s valid drop", name), 64'(rd_valid), 64'(0));
      end
    end
    enable = 1'b0;
  endtask

  task automatic write_all(input logic [DW-1:0] val);
    for (int i = 0; i < DEPTH; i++) begin
      enable = 1'b1;
      wren = 1'b1;
      wraddress = i[AW-1:0];
      datain = val;
      tick();
      model[i] = val;
    end
    enable = 1'b0;
    wren = 1'b0;
    tick();
  endtask

  initial begin
    passed = 0;
    total = 0;
    //            en    we    wa     ra     d     ev    cd    ed    edb
    tbl[0] = '{1'b1, 1'b1, 5'd7, 5'd7, 3'd2, 1'b0, 1'b0, 3'd0, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 5'd7, 5'd7, 3'd0, 1'b1, 1'b1, 3'd5, 3'd2};
    tbl[2] = '{1'b1, 1'b1, 5'd3, 5'd3, 3'd6, 1'b1, 1'b1, 3'd2, 3'd2};
    tbl[3] = '{1'b0, 1'b1, 5'd9, 5'd9, 3'd1, 1'b1, 1'b1, 3'd5, 3'd6};
    tbl[4] = '{1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b1, 3'd5, 3'd6};
    tbl[5] = '{1'b1, 1'b0, 5'd0, 5'd3, 3'd0, 1'b0, 1'b1, 3'd5, 3'd6};
    tbl[6] = '{1'b1, 1'b0, 5'd0, 5'd9, 3'd0, 1'b1, 1'b1, 3'd6, 3'd6};
    tbl[7] = '{1'b1, 1'b0, 5'd0, 5'd7, 3'd0, 1'b1, 1'b1, 3'd5, 3'd5};
    tbl[8] = '{1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b1, 1'b1, 3'd2, 3'd2};
    tbl[9] = '{1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b1, 3'd2, 3'd2};

    reset = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    wren = 1'b0;
    rdaddress = '0;
    wraddress = '0;
    datain = '0;

    repeat (2) tick();
    chk("reset busy", 64'(busy), 64'(1));
    chk("reset dataout", 64'(dataout), 64'(0));
    chk("reset rd_valid", 64'(rd_valid), 64'(0));
    reset = 1'b0;
    sweep_count("init sweep", -1, n);
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    read_all("init read");

    for (int k = 0; k < 10; k++) begin
      enable = tbl[k].en;
      wren = tbl[k].we;
      wraddress = tbl[k].wa;
      rdaddress = tbl[k].ra;
      datain = tbl[k].d;
      tick();
      chk($sformatf("vec%0d valid", k), 64'(rd_valid), 64'(tbl[k].ev));
      if (tbl[k].cd)
        chk($sformatf("vec%0d data", k), 64'(dataout), 64'(BYP ? tbl[k].edb : tbl[k].ed));
    end
    enable = 1'b0;
    wren = 1'b0;
    model[7] = 3'd2;
    model[3] = 3'd6;

    write_all(3'b111);
    read_all("all ones read");

    // clear from IDLE with user writes attempted throughout the sweep
    enable = 1'b1;
    wren = 1'b1;
    datain = 3'b000;
    wraddress = 5'd5;
    rdaddress = 5'd5;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear busy", 64'(busy), 64'(1));
    chk("clear dataout", 64'(dataout), 64'(0));
    chk("clear rd_valid", 64'(rd_valid), 64'(0));
    sweep_count("clear sweep", -1, n);
    enable = 1'b0;
    wren = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    read_all("after clear read");

    // async reset in the middle of a valid read result
    enable = 1'b1;
    rdaddress = 5'd4;
    tick();
    enable = 1'b0;
    tick();
    chk("pre reset valid", 64'(rd_valid), 64'(1));
    chk("pre reset data", 64'(dataout), 64'(INIT));
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", 64'(busy), 64'(1));
    chk("async reset dataout", 64'(dataout), 64'(0));
    chk("async reset rd_valid", 64'(rd_valid), 64'(0));
    repeat (2) tick();
    reset = 1'b0;

    // reset again at sweep counter 12; sweep must restart and run full length
    repeat (12) tick();
    chk("midsweep busy", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("midsweep reset busy", 64'(busy), 64'(1));
    chk("midsweep reset dataout", 64'(dataout), 64'(0));
    repeat (2) tick();
    reset = 1'b0;
    sweep_count("restart sweep", -1, n);

    // clear pulsed while busy must not extend the sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sweep_count("clear while busy", 10, n);
    read_all("final read");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
